// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, pre-decodes branch/call/ret, keeps a
// circular return-address stack and the IF/ID pipeline register.
module ifetch_unit #(
  parameter logic [4:0]  RESET_PC  = 5'd21,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [4:0]  ifid_pc,
  output logic        ifid_valid,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  logic [4:0]      pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [4:0]      ifpc_q, ifpc_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [4:0]      ras_q [RAS_DEPTH];
  logic [4:0]      ras_d [RAS_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            is_branch, is_call, is_ret;
  logic [4:0]      pc_inc, target;
  logic [PtrW-1:0] top_ptr;
  logic            ras_empty, ras_full;
  logic            unused_offset_hi;

  assign is_branch = (imem_data[15:12] == 4'b0001);
  assign is_call   = (imem_data[15:12] == 4'b1010);
  assign is_ret    = (imem_data[15:10] == 6'b111111);

  // Target is taken mod 32, so only the low offset bits contribute.
  assign pc_inc           = pc_q + 5'd1;
  assign target           = pc_inc + imem_data[4:0];
  assign unused_offset_hi = ^imem_data[11:5];

  // wr_ptr_q names the next free slot; the newest entry sits just below it.
  assign top_ptr   = wr_ptr_q - PtrW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntFull);

  assign imem_addr     = rst_n ? pc_q : RESET_PC;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ifpc_q;
  assign ifid_valid    = valid_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (flush) begin
      pc_d    = redirect_pc;
      instr_d = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = imem_data;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_inc;
      if (is_branch) begin
        pc_d = target;
      end else if (is_call) begin
        pc_d             = target;
        ras_d[wr_ptr_q]  = pc_inc;
        wr_ptr_d         = wr_ptr_q + PtrW'(1);
        // A full stack overwrites its oldest slot, which is the one at wr_ptr_q.
        if (ras_full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else if (is_ret) begin
        if (ras_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d     = ras_q[top_ptr];
          wr_ptr_d = top_ptr;
          cnt_d    = cnt_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ifpc_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stack contents need no reset; the count alone decides what is live.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based reference model checked every cycle, plus
// directed address sequences with hand-computed expectations.
module tb_ifetch_unit;

  localparam int unsigned RESET_PC  = 21;
  localparam int unsigned RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic [4:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [4:0]  ifid_pc;
  logic        ifid_valid;
  logic        ras_overflow;
  logic        ras_underflow;

  logic [15:0] mem [32];

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_unit #(
    .RESET_PC (5'(RESET_PC)),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_valid   (ifid_valid),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: PC as an integer, return stack as a queue (newest at back).
  int          m_pc;
  logic [15:0] m_instr;
  int          m_ifpc;
  bit          m_valid, m_ovf, m_unf, m_known = 1'b0;
  int          ras[$];

  always @(posedge clk) begin
    logic [15:0] w;
    int          off, tgt, nxt;
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = '0; m_ifpc = 0; m_valid = 0;
      m_ovf = 0; m_unf = 0; ras.delete(); m_known = 1'b1;
    end else if (m_known) begin
      w   = mem[m_pc];
      off = int'($signed(w[11:0]));
      tgt = (((m_pc + 1 + off) % 32) + 32) % 32;
      nxt = (m_pc + 1) % 32;
      if (flush) begin
        m_valid = 0; m_instr = '0; m_ifpc = 0; m_pc = redirect_pc;
      end else if (!stall) begin
        m_instr = w; m_ifpc = m_pc; m_valid = 1;
        if (w[15:12] == 4'h1) begin
          m_pc = tgt;
        end else if (w[15:12] == 4'hA) begin
          if (ras.size() == RAS_DEPTH) begin
            void'(ras.pop_front());
            m_ovf = 1;
          end
          ras.push_back(nxt);
          m_pc = tgt;
        end else if (w[15:10] == 6'h3F) begin
          if (ras.size() > 0) m_pc = ras.pop_back();
          else begin m_unf = 1; m_pc = nxt; end
        end else begin
          m_pc = nxt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_imem_addr", 32'(imem_addr), rst_n ? 32'(m_pc) : 32'(RESET_PC));
      chk("model_ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("model_ifid_instr", 32'(ifid_instr), 32'(m_instr));
      chk("model_ifid_pc", 32'(ifid_pc), 32'(m_ifpc));
      chk("model_ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      chk("model_ras_underflow", 32'(ras_underflow), 32'(m_unf));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int seq1 [15] = '{22, 23, 25, 26, 27, 24, 28, 29, 30, 31, 0, 1, 2, 3, 2};
  int seq2 [10] = '{10, 12, 14, 16, 18, 17, 15, 13, 11, 12};

  initial begin
    int prev;
    for (int i = 0; i < 32; i++) mem[i] = 16'h2000 | 16'(i);
    mem[21] = 16'hF400;
    mem[23] = 16'hA001;  // call -> 25, push 24
    mem[27] = 16'hFC00;  // ret
    mem[24] = 16'h1003;  // branch -> 28
    mem[3]  = 16'h1FFE;  // branch -> 2
    for (int a = 8; a <= 16; a += 2) mem[a] = 16'hA001;
    for (int a = 11; a <= 17; a += 2) mem[a] = 16'hFC00;
    mem[18] = 16'hFC00;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_ifid_valid", 32'(ifid_valid), 0);
    chk("reset_ifid_instr", 32'(ifid_instr), 0);
    chk("reset_imem_addr", 32'(imem_addr), 21);
    rst_n = 1'b1;

    prev = 21;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("seq1_imem_addr", 32'(imem_addr), 32'(seq1[k]));
      chk("seq1_ifid_pc", 32'(ifid_pc), 32'(prev));
      if (k == 0) chk("first_ifid_instr", 32'(ifid_instr), 32'h0000F400);
      prev = seq1[k];
    end
    chk("seq1_flags", {30'd0, ras_overflow, ras_underflow}, 0);

    flush = 1'b1; stall = 1'b1; redirect_pc = 5'd5;
    step();
    chk("flush_stall_addr", 32'(imem_addr), 5);
    chk("flush_stall_valid", 32'(ifid_valid), 0);
    stall = 1'b0; redirect_pc = 5'd25;
    step();
    chk("flush_addr", 32'(imem_addr), 25);
    flush = 1'b0;
    step();
    chk("pre_stall_addr", 32'(imem_addr), 26);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_addr", 32'(imem_addr), 26);
      chk("stall_ifid_pc", 32'(ifid_pc), 25);
      chk("stall_ifid_instr", 32'(ifid_instr), 32'h00002019);
      chk("stall_ifid_valid", 32'(ifid_valid), 1);
    end
    stall = 1'b0;
    step();
    chk("post_stall_addr", 32'(imem_addr), 27);
    chk("post_stall_ifid_pc", 32'(ifid_pc), 26);

    flush = 1'b1; redirect_pc = 5'd8;
    step();
    chk("flush_ret_addr", 32'(imem_addr), 8);
    flush = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("seq2_imem_addr", 32'(imem_addr), 32'(seq2[k]));
      chk("seq2_overflow", 32'(ras_overflow), (k >= 4) ? 1 : 0);
      chk("seq2_underflow", 32'(ras_underflow), (k == 9) ? 1 : 0);
    end
    step();
    chk("refill_addr_a", 32'(imem_addr), 14);
    step();
    chk("refill_addr_b", 32'(imem_addr), 16);

    rst_n = 1'b0; stall = 1'b1;
    step();
    chk("midreset_addr", 32'(imem_addr), 21);
    chk("midreset_valid", 32'(ifid_valid), 0);
    chk("midreset_ifid_pc", 32'(ifid_pc), 0);
    chk("midreset_flags", {30'd0, ras_overflow, ras_underflow}, 0);
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("after_reset_addr", 32'(imem_addr), 22);
    chk("after_reset_ifid_pc", 32'(ifid_pc), 21);
    flush = 1'b1; redirect_pc = 5'd11;
    step();
    flush = 1'b0;
    step();
    chk("empty_ras_ret_addr", 32'(imem_addr), 12);
    chk("empty_ras_underflow", 32'(ras_underflow), 1);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
